// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, direction and timer types for the memory access sequencer
package cpu_pkg;

  // Sequencer states for one external bus access.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mem_state_e;

  // Direction of the access latched in IDLE.
  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_dir_e;

  // All bus-cycle timers are 8-bit down-counters.
  localparam int TIMER_WIDTH = 8;

  // Converts an integer cycle count into a timer load value.
  function automatic logic [TIMER_WIDTH-1:0] timer_load(input int cycles);
    return TIMER_WIDTH'(cycles);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - loadable 8-bit down-counter with a zero flag
module wait_timer
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] load_val,
  input  logic                   dec,
  output logic                   zero
);

  logic [TIMER_WIDTH-1:0] count;

  // Load wins over decrement; decrementing stops at zero so the flag stays set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - memory bus sequencer with wait states and ready handshake; MEM_CTRL_TIMEOUT_EN adds a stall timeout
module mem_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int WAIT_STATES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ld_mdr_rd,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_cs,
  output logic                  bus_we,
  input  logic                  bus_ready,
  output logic                  fault
);

  // Both counts must fit the 8-bit timers; the timeout needs at least one cycle.
  if (WAIT_STATES < 0 || WAIT_STATES > 255 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("mem_ctrl: WAIT_STATES or TIMEOUT_CYCLES out of range");
  end

  mem_state_e state;
  mem_dir_e   dir;

  logic wait_load;
  logic wait_dec;
  logic wait_zero;

  // Both timers are armed in SETUP; the wait counter only runs while nonzero in WAIT.
  assign wait_load = (state == SETUP);
  assign wait_dec  = (state == WAIT) && !wait_zero;

  wait_timer u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (wait_load),
    .load_val (timer_load(WAIT_STATES)),
    .dec      (wait_dec),
    .zero     (wait_zero)
  );

`ifdef MEM_CTRL_TIMEOUT_EN
  logic stall;
  logic to_dec;
  logic to_zero;

  // A stall cycle is a WAIT cycle after the wait states with the memory not ready.
  // Loading TIMEOUT_CYCLES-1 makes the timer hit zero on the last tolerated stall,
  // so the access gives up exactly TIMEOUT_CYCLES stall cycles after expiry.
  assign stall  = (state == WAIT) && wait_zero && !bus_ready;
  assign to_dec = stall && !to_zero;

  wait_timer u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (wait_load),
    .load_val (timer_load(TIMEOUT_CYCLES - 1)),
    .dec      (to_dec),
    .zero     (to_zero)
  );
`else
  assign fault = 1'b0;
`endif

  // Access sequencer; every bus-facing and control-facing output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= READ;
      rd_data   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_cs    <= 1'b0;
      bus_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ld_mdr_rd <= 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
      fault     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Write wins when control raises both requests together.
          if (mem_wr || mem_rd) begin
            dir       <= mem_wr ? WRITE : READ;
            bus_addr  <= addr;
            bus_wdata <= wr_data;
            bus_cs    <= 1'b1;
            bus_we    <= mem_wr;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          state <= WAIT;
        end
        WAIT: begin
          // Ready is only honoured once the programmed wait states have elapsed.
          if (wait_zero && bus_ready) begin
            if (dir == READ) begin
              rd_data <= bus_rdata;
            end
            ld_mdr_rd <= (dir == READ);
            done      <= 1'b1;
            bus_cs    <= 1'b0;
            bus_we    <= 1'b0;
            state     <= DONE;
          end
`ifdef MEM_CTRL_TIMEOUT_EN
          else if (stall && to_zero) begin
            fault  <= 1'b1;
            done   <= 1'b1;
            bus_cs <= 1'b0;
            bus_we <= 1'b0;
            state  <= DONE;
          end
`endif
        end
        DONE: begin
          done      <= 1'b0;
          ld_mdr_rd <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ld_mdr_rd;
  logic        busy;
  logic        done;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_cs;
  logic        bus_we;
  logic        bus_ready;
  logic        fault;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  mem_ctrl #(
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (32),
    .WAIT_STATES    (2),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .ld_mdr_rd (ld_mdr_rd),
    .busy      (busy),
    .done      (done),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_cs    (bus_cs),
    .bus_we    (bus_we),
    .bus_ready (bus_ready),
    .fault     (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Request in cycle 0 (inputs set before the closing edge), then observe each cycle
  // at the falling edge. mask[i] drives bus_ready in cycle i; bus_rdata carries gd only
  // in cycle 'good' and its complement otherwise. Requests drop from cycle 'hold' on,
  // and addr changes to a_late in cycle 1.
  task automatic run_access(
    input  logic        r,
    input  logic        w,
    input  logic [15:0] a,
    input  logic [15:0] a_late,
    input  logic [31:0] wd,
    input  logic [31:0] gd,
    input  logic [31:0] mask,
    input  int          good,
    input  int          hold,
    output int          lat,
    output logic        ld_seen,
    output logic [31:0] rd_done,
    output logic [31:0] rd_before,
    output logic [31:0] cs_bits,
    output logic [31:0] we_bits,
    output logic [31:0] busy_bits
  );
    addr      = a;
    wr_data   = wd;
    mem_rd    = r;
    mem_wr    = w;
    bus_ready = mask[0];
    bus_rdata = (good == 0) ? gd : ~gd;
    lat       = -1;
    ld_seen   = 1'b0;
    rd_done   = '0;
    rd_before = '0;
    cs_bits   = '0;
    we_bits   = '0;
    busy_bits = '0;
    for (int i = 1; i < 32 && lat < 0; i++) begin
      @(negedge clk);
      cs_bits[i]   = bus_cs;
      we_bits[i]   = bus_we;
      busy_bits[i] = busy;
      if (done === 1'b1) begin
        lat     = i;
        ld_seen = ld_mdr_rd;
        rd_done = rd_data;
      end else begin
        rd_before = rd_data;
      end
      if (i >= hold) begin
        mem_rd = 1'b0;
        mem_wr = 1'b0;
      end
      if (i == 1) addr = a_late;
      bus_ready = mask[i];
      bus_rdata = (i == good) ? gd : ~gd;
    end
  endtask

  int          lat;
  logic        ld_seen;
  logic [31:0] rd_done;
  logic [31:0] rd_before;
  logic [31:0] cs_bits;
  logic [31:0] we_bits;
  logic [31:0] busy_bits;
  logic        seen_done;
  logic        seen_busy;

  initial begin
    rst       = 1'b1;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    addr      = '0;
    wr_data   = '0;
    bus_rdata = '0;
    bus_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_cs_we_busy_done_ld_fault", {26'd0, bus_cs, bus_we, busy, done, ld_mdr_rd, fault}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_bus_addr_wdata", {16'd0, bus_addr} | bus_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Read, ready tied high: cs in c1..c4, done with load and data in c5
    run_access(1'b1, 1'b0, 16'h0010, 16'h0010, 32'h0, 32'hDEADBEEF, 32'hFFFF_FFFF, 4, 1,
               lat, ld_seen, rd_done, rd_before, cs_bits, we_bits, busy_bits);
    chk("rd_latency", 32'(lat), 32'd5);
    chk("rd_ld_mdr", {31'd0, ld_seen}, 32'd1);
    chk("rd_data", rd_done, 32'hDEADBEEF);
    chk("rd_data_before_capture", rd_before, 32'd0);
    chk("rd_cs_cycles", cs_bits, 32'h0000_001E);
    chk("rd_we_cycles", we_bits, 32'h0);
    chk("rd_busy_cycles", busy_bits, 32'h0000_003E);
    chk("rd_bus_addr", {16'd0, bus_addr}, 32'h0010);
    @(negedge clk);
    chk("rd_after_idle", {29'd0, busy, done, ld_mdr_rd}, 32'd0);

    // Write: we throughout, no MDR load, rd_data untouched
    run_access(1'b0, 1'b1, 16'h0020, 16'h0020, 32'h12345678, 32'h55555555, 32'hFFFF_FFFF, 4, 1,
               lat, ld_seen, rd_done, rd_before, cs_bits, we_bits, busy_bits);
    chk("wr_latency", 32'(lat), 32'd5);
    chk("wr_ld_mdr", {31'd0, ld_seen}, 32'd0);
    chk("wr_rd_data_kept", rd_done, 32'hDEADBEEF);
    chk("wr_we_cycles", we_bits, 32'h0000_001E);
    chk("wr_bus_wdata", bus_wdata, 32'h12345678);
    chk("wr_bus_addr", {16'd0, bus_addr}, 32'h0020);
    @(negedge clk);

    // Ready high during counted waits (ignored), low 3 cycles after expiry, then high in c7
    run_access(1'b1, 1'b0, 16'h0024, 16'h0024, 32'h0, 32'hCAFEF00D, 32'hFFFF_FF8F, 7, 1,
               lat, ld_seen, rd_done, rd_before, cs_bits, we_bits, busy_bits);
    chk("stall_latency", 32'(lat), 32'd8);
    chk("stall_ld_mdr", {31'd0, ld_seen}, 32'd1);
    chk("stall_rd_data", rd_done, 32'hCAFEF00D);
    chk("stall_rd_data_before", rd_before, 32'hDEADBEEF);
    chk("stall_cs_cycles", cs_bits, 32'h0000_00FE);
    @(negedge clk);

    // Both requests high and held into WAIT with a changing address: one write only
    run_access(1'b1, 1'b1, 16'h0030, 16'h0099, 32'hA5A5A5A5, 32'h11111111, 32'hFFFF_FFFF, 4, 4,
               lat, ld_seen, rd_done, rd_before, cs_bits, we_bits, busy_bits);
    chk("both_latency", 32'(lat), 32'd5);
    chk("both_is_write", we_bits, 32'h0000_001E);
    chk("both_ld_mdr", {31'd0, ld_seen}, 32'd0);
    chk("both_rd_data_kept", rd_done, 32'hCAFEF00D);
    chk("both_bus_addr_held", {16'd0, bus_addr}, 32'h0030);
    chk("both_bus_wdata", bus_wdata, 32'hA5A5A5A5);
    seen_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen_busy = seen_busy | busy;
    end
    chk("idle_stays_idle", {31'd0, seen_busy}, 32'd0);

    // Reset in WAIT: cs drops without a clock edge, access lost, no done
    addr      = 16'h0050;
    mem_rd    = 1'b1;
    bus_ready = 1'b1;
    bus_rdata = 32'h99999999;
    @(negedge clk);
    mem_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_cs_in_wait", {31'd0, bus_cs}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_cs", {31'd0, bus_cs}, 32'd0);
    chk("async_rst_outputs", {27'd0, bus_we, busy, done, ld_mdr_rd, fault}, 32'd0);
    chk("async_rst_rd_data", rd_data, 32'd0);
    chk("async_rst_bus_addr", {16'd0, bus_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen_done = seen_done | done;
      seen_busy = seen_busy | busy;
    end
    chk("rst_no_done", {30'd0, seen_done, seen_busy}, 32'd0);

    // Read after reset completes normally
    run_access(1'b1, 1'b0, 16'h0060, 16'h0060, 32'h0, 32'h0BADF00D, 32'hFFFF_FFFF, 4, 1,
               lat, ld_seen, rd_done, rd_before, cs_bits, we_bits, busy_bits);
    chk("post_rst_latency", 32'(lat), 32'd5);
    chk("post_rst_ld_mdr", {31'd0, ld_seen}, 32'd1);
    chk("post_rst_rd_data", rd_done, 32'h0BADF00D);
    @(negedge clk);

`ifdef MEM_CTRL_TIMEOUT_EN
    // Ready stuck low: 4 stall cycles tolerated (c4..c7), DONE in c8 with fault
    run_access(1'b1, 1'b0, 16'h0070, 16'h0070, 32'h0, 32'h77777777, 32'h0, 99, 1,
               lat, ld_seen, rd_done, rd_before, cs_bits, we_bits, busy_bits);
    chk("to_latency", 32'(lat), 32'd8);
    chk("to_ld_mdr", {31'd0, ld_seen}, 32'd0);
    chk("to_rd_data_kept", rd_done, 32'h0BADF00D);
    chk("to_fault_set", {31'd0, fault}, 32'd1);
    @(negedge clk);
    run_access(1'b1, 1'b0, 16'h0074, 16'h0074, 32'h0, 32'h31415926, 32'hFFFF_FFFF, 4, 1,
               lat, ld_seen, rd_done, rd_before, cs_bits, we_bits, busy_bits);
    chk("to_next_latency", 32'(lat), 32'd5);
    chk("to_next_rd_data", rd_done, 32'h31415926);
    chk("to_fault_sticky", {31'd0, fault}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("to_fault_cleared", {31'd0, fault}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
`else
    chk("fault_tied_low", {31'd0, fault}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory access sequencer between the control unit and the external synchronous memory bus. Accepts single-cycle-sampled `mem_rd`/`mem_wr` requests from control, the address from MAR and the write data from MDR, then runs a bus cycle with a programmable number of wait states plus `bus_ready` handshaking. Returns read data with a load pulse for MDR and a `done` pulse so control can advance its microsequence.

## Interface
- `ADDR_WIDTH`, 16: bus address width.
- `DATA_WIDTH`, 32: data width.
- `WAIT_STATES`, 2: minimum wait cycles per access, 0..255.
- `TIMEOUT_CYCLES`, 255: extra WAIT cycles tolerated after wait states expire; used only with the timeout macro.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_rd`  in  1  read request from control.
- `mem_wr`  in  1  write request from control.
- `addr`  in  ADDR_WIDTH  address from MAR.
- `wr_data`  in  DATA_WIDTH  write data from MDR.
- `rd_data`  out  DATA_WIDTH  registered read data to MDR.
- `ld_mdr_rd`  out  1  one-cycle pulse: MDR loads `rd_data`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `bus_addr`  out  ADDR_WIDTH  latched address.
- `bus_wdata`  out  DATA_WIDTH  latched write data.
- `bus_rdata`  in  DATA_WIDTH  memory read data.
- `bus_cs`  out  1  chip select.
- `bus_we`  out  1  write enable, valid while `bus_cs` is high.
- `bus_ready`  in  1  memory ready.
- `fault`  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, SETUP, WAIT, DONE.
- **IDLE**
  - On `mem_wr` or `mem_rd`, latch `addr`, `wr_data` and the direction, then go to SETUP.
  - If both are high, the access is a write.
  - If neither is high, stay in IDLE.
- **SETUP**
  - Lasts one cycle.
  - `bus_cs`=1 and `bus_we`=direction.
  - Load the wait counter with `WAIT_STATES`, then go to WAIT.
- **WAIT**
  - `bus_cs` stays high.
  - If the counter is nonzero, decrement it.
  - Otherwise, if `bus_ready` is high: on a read, capture `bus_rdata` into `rd_data`; then go to DONE.
- **DONE**
  - Lasts one cycle.
  - `bus_cs`=0 and `done`=1.
  - `ld_mdr_rd`=1 only for a successful read.
  - Next state is IDLE.
- Requests are ignored outside IDLE.
- Control must drop its request on the edge that ends DONE. A request still high in IDLE starts a new access.
- `bus_addr`/`bus_wdata` hold their latched values until the next access.
- `rd_data` is updated only by a read capture.
- Reset values:
  - state IDLE.
  - `rd_data`, `bus_addr`, `bus_wdata` all 0.
  - `bus_cs`, `bus_we`, `busy`, `done`, `ld_mdr_rd`, `fault` all 0.
- Reset mid-access:
  - `bus_cs` drops immediately (asynchronously).
  - No `done` pulse is produced.
  - The access is lost.

## Timing
- Request seen in IDLE in cycle c0 gives SETUP in c1 and WAIT in c2..c2+N+k. N=`WAIT_STATES`; k = cycles `bus_ready` stays low after the counter reaches 0.
- DONE is in c3+N+k. With N=2, k=0, `done` is asserted 5 cycles after c0.
- `bus_rdata` is sampled on the edge that leaves WAIT, and `rd_data` is valid in the DONE cycle.
- Back-to-back accesses are a minimum of N+4 cycles apart.
- N=0 case: WAIT lasts one cycle if `bus_ready` is high.
- `bus_ready` high during SETUP or during the counted wait cycles is ignored.

## Configuration
- Macro: `MEM_CTRL_TIMEOUT_EN`.
- Defined:
  - A timeout counter counts WAIT cycles once the wait counter is 0 and `bus_ready` is low.
  - When it reaches `TIMEOUT_CYCLES`, go to DONE with `done`=1 and `ld_mdr_rd`=0; `rd_data` is unchanged.
  - `fault` is set and stays high until `rst`.
- Undefined:
  - WAIT is unbounded.
  - `fault` is tied 0.
  - No timeout counter logic exists.

## Structure
- Shared package `cpu_pkg` holds:
  - the `mem_state_e` enum (IDLE, SETUP, WAIT, DONE);
  - the `mem_dir_e` enum (READ, WRITE).
- One sub-module, `wait_timer`:
  - loadable 8-bit down-counter with a zero flag;
  - instantiated once for the wait states, and a second time for the timeout when the macro is defined.

## Test plan
- Read, N=2, `bus_ready` tied 1, `addr`=0x0010, `bus_rdata`=0xDEADBEEF → `bus_cs` high for cycles c1..c4; in c5 `done`=1, `ld_mdr_rd`=1, `rd_data`=0xDEADBEEF.
- Write, `addr`=0x0020, `wr_data`=0x12345678 → `bus_we`=1 with `bus_wdata`=0x12345678 throughout; `done` in c5; `ld_mdr_rd`=0; `rd_data` unchanged.
- `bus_ready` held low 3 cycles after wait states expire → `done` in c8; data captured only on the `bus_ready` edge.
- `mem_rd` and `mem_wr` both high → write cycle; second request during WAIT ignored; request dropped after `done` → IDLE stays idle.
- `rst` asserted in WAIT → `bus_cs`=0 in the same cycle; all outputs 0; no `done`; a new read after reset completes normally.
- `MEM_CTRL_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `bus_ready` stuck 0 → `done`=1 with `ld_mdr_rd`=0; `fault`=1 and stays high until `rst`.
